// File: rtl/mchan_ipa_pkg.sv
// mchan_ipa_pkg: transaction word layout, direction encoding and FSM states shared by queue and unpackers
package mchan_ipa_pkg;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned TCDM_W    = 16;
    localparam int unsigned EXT_W     = 16;
    localparam int unsigned OPC_W     = 3;
    localparam int unsigned TQ_W      = LEN_W + TCDM_W + EXT_W + 1 + OPC_W;
    localparam int unsigned BURST_MAX = 64;

    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned TCDM_LSB = LEN_W;
    localparam int unsigned EXT_LSB  = LEN_W + TCDM_W;
    localparam int unsigned DIR_BIT  = LEN_W + TCDM_W + EXT_W;

    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } dir_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } unpack_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        dir_e              dir;
        logic [EXT_W-1:0]  ext_add;
        logic [TCDM_W-1:0] tcdm_add;
        logic [LEN_W-1:0]  len;
    } burst_word_t;

endpackage

// File: rtl/trans_burst_calc_ipa.sv
// trans_burst_calc_ipa: burst length = min(remaining, bytes left to the next burst-aligned boundary)
module trans_burst_calc_ipa
    import mchan_ipa_pkg::*;
#(
    parameter int unsigned LEN_WIDTH       = LEN_W,
    parameter int unsigned MAX_BURST_BYTES = BURST_MAX,
    parameter int unsigned OFF_WIDTH       = $clog2(MAX_BURST_BYTES),
    parameter int unsigned BURST_LEN_WIDTH = $clog2(MAX_BURST_BYTES) + 1
) (
    input  logic [OFF_WIDTH-1:0]       i_off,
    input  logic [LEN_WIDTH-1:0]       i_rem,
    output logic [BURST_LEN_WIDTH-1:0] o_len,
    output logic                       o_last
);

    logic [LEN_WIDTH:0] w_rem, w_room, w_min;

    assign w_rem  = {1'b0, i_rem};
    assign w_room = (LEN_WIDTH+1)'(MAX_BURST_BYTES) - (LEN_WIDTH+1)'(i_off);
    assign w_min  = (w_rem < w_room) ? w_rem : w_room;
    assign o_len  = BURST_LEN_WIDTH'(w_min);
    assign o_last = (w_rem == w_min);

endmodule

// File: rtl/trans_unpack_ipa.sv
// trans_unpack_ipa: pops queued transactions and splits them into bursts that never cross a MAX_BURST_BYTES boundary of ext
module trans_unpack_ipa
    import mchan_ipa_pkg::*;
#(
    parameter int unsigned TRANS_QUEUE_WIDTH = TQ_W,
    parameter int unsigned TCDM_ADD_WIDTH    = TCDM_W,
    parameter int unsigned EXT_ADD_WIDTH     = EXT_W,
    parameter int unsigned MCHAN_LEN_WIDTH   = LEN_W,
    parameter int unsigned MAX_BURST_BYTES   = BURST_MAX,
    parameter int unsigned BURST_LEN_WIDTH   = $clog2(MAX_BURST_BYTES) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         trans_req_i,
    output logic                         trans_gnt_o,
    input  logic [TRANS_QUEUE_WIDTH-1:0] trans_dat_i,
    output logic                         burst_req_o,
    input  logic                         burst_gnt_i,
    output logic [TRANS_QUEUE_WIDTH-1:0] burst_dat_o,
    output logic [BURST_LEN_WIDTH-1:0]   burst_len_o,
    output logic                         burst_last_o,
    output logic                         busy_o
);

    localparam int unsigned LEN  = MCHAN_LEN_WIDTH;
    localparam int unsigned TCDM = TCDM_ADD_WIDTH;
    localparam int unsigned EXT  = EXT_ADD_WIDTH;
    localparam int unsigned HDR  = TRANS_QUEUE_WIDTH - LEN - TCDM - EXT;
    localparam int unsigned OFF  = $clog2(MAX_BURST_BYTES);

    unpack_state_e        r_state, w_state_d;
    logic [EXT-1:0]       r_ext;
    logic [TCDM-1:0]      r_tcdm;
    logic [LEN-1:0]       r_rem;
    logic [HDR-1:0]       r_hdr;
    logic [BURST_LEN_WIDTH-1:0] w_len;
    logic                 w_last, w_busy, w_acc, w_done, w_load;

    trans_burst_calc_ipa #(
        .LEN_WIDTH       (LEN),
        .MAX_BURST_BYTES (MAX_BURST_BYTES),
        .OFF_WIDTH       (OFF),
        .BURST_LEN_WIDTH (BURST_LEN_WIDTH)
    ) u_calc (
        .i_off  (r_ext[OFF-1:0]),
        .i_rem  (r_rem),
        .o_len  (w_len),
        .o_last (w_last)
    );

    assign w_busy      = (r_state == BUSY);
    assign w_acc       = w_busy & burst_gnt_i;
    assign w_done      = w_acc & w_last;
    assign trans_gnt_o = ~w_busy | w_done;
    // zero-length words are popped but never start a transfer
    assign w_load      = trans_req_i & trans_gnt_o & (trans_dat_i[LEN-1:0] != '0);

    always_comb begin
        w_state_d = r_state;
        if (w_load)
            w_state_d = BUSY;
        else if (w_done)
            w_state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= IDLE;
        else
            r_state <= w_state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ext  <= '0;
            r_tcdm <= '0;
            r_rem  <= '0;
            r_hdr  <= '0;
        end else if (w_load) begin
            r_ext  <= trans_dat_i[LEN+TCDM +: EXT];
            r_tcdm <= trans_dat_i[LEN +: TCDM];
            r_rem  <= trans_dat_i[LEN-1:0];
            r_hdr  <= trans_dat_i[TRANS_QUEUE_WIDTH-1 -: HDR];
        end else if (w_acc) begin
            r_ext  <= r_ext + EXT'(w_len);
            r_tcdm <= r_tcdm + TCDM'(w_len);
            r_rem  <= r_rem - LEN'(w_len);
        end
    end

    assign burst_req_o  = w_busy;
    assign busy_o       = w_busy;
    assign burst_len_o  = w_len;
    assign burst_last_o = w_busy & w_last;
    assign burst_dat_o  = {r_hdr, r_ext, r_tcdm, LEN'(w_len)};

endmodule

// File: tb/tb_trans_unpack_ipa.sv
// tb_trans_unpack_ipa: directed vectors with hand-computed bursts for trans_unpack_ipa
module tb_trans_unpack_ipa;

    localparam int TQW = 52;
    localparam int BLW = 7;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b1;
    logic           trans_req_i = 1'b0;
    logic           burst_gnt_i = 1'b0;
    logic [TQW-1:0] trans_dat_i = '0;
    logic           trans_gnt_o, burst_req_o, burst_last_o, busy_o;
    logic [TQW-1:0] burst_dat_o;
    logic [BLW-1:0] burst_len_o;

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] exp_hdr = '0;

    always #5 clk_i = ~clk_i;

    trans_unpack_ipa #(
        .TRANS_QUEUE_WIDTH (TQW),
        .TCDM_ADD_WIDTH    (16),
        .EXT_ADD_WIDTH     (16),
        .MCHAN_LEN_WIDTH   (16),
        .MAX_BURST_BYTES   (64),
        .BURST_LEN_WIDTH   (BLW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .trans_req_i  (trans_req_i),
        .trans_gnt_o  (trans_gnt_o),
        .trans_dat_i  (trans_dat_i),
        .burst_req_o  (burst_req_o),
        .burst_gnt_i  (burst_gnt_i),
        .burst_dat_o  (burst_dat_o),
        .burst_len_o  (burst_len_o),
        .burst_last_o (burst_last_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TQW-1:0] mk(input logic [2:0] opc, input logic dir,
                                          input logic [15:0] ext, input logic [15:0] tcdm,
                                          input logic [15:0] len);
        return {opc, dir, ext, tcdm, len};
    endfunction

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push(input string tag, input logic [TQW-1:0] w);
        check({tag, ".gnt"}, trans_gnt_o, 1);
        trans_req_i = 1'b1;
        trans_dat_i = w;
        exp_hdr     = w[51:48];
        step();
        trans_req_i = 1'b0;
    endtask

    task automatic expect_burst(input string tag, input logic [15:0] ext, input logic [15:0] tcdm,
                                input logic [15:0] len, input logic last);
        check({tag, ".req"},  burst_req_o, 1);
        check({tag, ".busy"}, busy_o, 1);
        check({tag, ".ext"},  burst_dat_o[47:32], ext);
        check({tag, ".tcdm"}, burst_dat_o[31:16], tcdm);
        check({tag, ".dlen"}, burst_dat_o[15:0], len);
        check({tag, ".len"},  burst_len_o, len);
        check({tag, ".last"}, burst_last_o, last);
        check({tag, ".hdr"},  burst_dat_o[51:48], exp_hdr);
        burst_gnt_i = 1'b1;
        step();
        burst_gnt_i = 1'b0;
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst.req",  burst_req_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.gnt",  trans_gnt_o, 1);
        check("rst.dat",  burst_dat_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // split at the 0x1040 boundary
        push("A", mk(3'd5, 1'b1, 16'h1030, 16'h0200, 16'h0050));
        expect_burst("A0", 16'h1030, 16'h0200, 16'd16, 1'b0);
        expect_burst("A1", 16'h1040, 16'h0210, 16'd64, 1'b1);
        check("A.idle", busy_o, 0);
        check("A.noreq", burst_req_o, 0);

        push("B", mk(3'd2, 1'b0, 16'h2000, 16'h0300, 16'd64));
        expect_burst("B0", 16'h2000, 16'h0300, 16'd64, 1'b1);
        push("B1", mk(3'd1, 1'b1, 16'h2000, 16'h0340, 16'd1));
        expect_burst("B1", 16'h2000, 16'h0340, 16'd1, 1'b1);

        // ext wraps past 0xFFFF
        push("C", mk(3'd7, 1'b0, 16'hFFF0, 16'h0100, 16'h0020));
        expect_burst("C0", 16'hFFF0, 16'h0100, 16'd16, 1'b0);
        expect_burst("C1", 16'h0000, 16'h0110, 16'd16, 1'b1);

        push("D0", mk(3'd0, 1'b0, 16'h1234, 16'h5678, 16'd0));
        check("D.zbusy", busy_o, 0);
        check("D.zreq",  burst_req_o, 0);
        push("D1", mk(3'd4, 1'b1, 16'h3000, 16'h0400, 16'd64));
        expect_burst("D", 16'h3000, 16'h0400, 16'd64, 1'b1);

        // stall, then a zero-bubble handover to the next transaction
        push("E", mk(3'd6, 1'b0, 16'h1030, 16'h0500, 16'h0050));
        for (int i = 0; i < 5; i++) begin
            step();
            check("E.st.req",  burst_req_o, 1);
            check("E.st.ext",  burst_dat_o[47:32], 16'h1030);
            check("E.st.len",  burst_len_o, 16);
            check("E.st.last", burst_last_o, 0);
        end
        expect_burst("E0", 16'h1030, 16'h0500, 16'd16, 1'b0);
        trans_req_i = 1'b1;
        trans_dat_i = mk(3'd3, 1'b1, 16'h4010, 16'h0600, 16'd8);
        #1 check("E.nogrant", trans_gnt_o, 0);
        expect_burst("E1", 16'h1040, 16'h0510, 16'd64, 1'b1);
        trans_req_i = 1'b0;
        exp_hdr = 4'h7;
        expect_burst("E2", 16'h4010, 16'h0600, 16'd8, 1'b1);

        // asynchronous reset during the 2nd of 3 bursts
        push("F", mk(3'd1, 1'b0, 16'h5000, 16'h0700, 16'h00C0));
        expect_burst("F0", 16'h5000, 16'h0700, 16'd64, 1'b0);
        check("F.mid", burst_req_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("F.rreq",  burst_req_o, 0);
        check("F.rbusy", busy_o, 0);
        check("F.rgnt",  trans_gnt_o, 1);
        check("F.rdat",  burst_dat_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        push("G", mk(3'd2, 1'b1, 16'h6004, 16'h0800, 16'd4));
        expect_burst("G", 16'h6004, 16'h0800, 16'd4, 1'b1);
        check("G.idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
